mult_iter: RTL

- Parametrised multi-cycle integer multiplier; successor to the single-cycle combinational array multiplier in the datapath.
- Trades latency for area: processes DIGIT multiplier bits per cycle, accumulating shifted partial products into a 2*WIDTH accumulator.
- Adds a start/busy/done handshake, an abort input for pipeline flush, and a held result register.
- Sits beside the ALU in EX; drives the HI/LO write path.

---
 rtl/mult_iter_pkg.sv | 28 ++
 rtl/mult_pp_digit.sv | 23 ++
 rtl/mult_iter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/mult_iter_pkg.sv
// mult_iter_pkg: shared types and elaboration helpers for the iterative
// multiplier.
//   state_e   - controller states (IDLE, CALC, FIX)
//   clog2     - ceiling log2, never less than 1, sizes the step counter
//   num_steps - number of CALC cycles for a WIDTH/DIGIT configuration
package mult_iter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned num_steps(input int unsigned w,
                                            input int unsigned d);
    return w / d;
  endfunction

endpackage

// File: rtl/mult_pp_digit.sv
// mult_pp_digit: combinational WIDTH x DIGIT partial product.
//   mag_a_i [WIDTH]       multiplicand magnitude
//   digit_i [DIGIT]       low DIGIT bits of the remaining multiplier
//   pp_o    [WIDTH+DIGIT] mag_a_i * digit_i
module mult_pp_digit
  import mult_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic [WIDTH-1:0]       mag_a_i,
  input  logic [DIGIT-1:0]       digit_i,
  output logic [WIDTH+DIGIT-1:0] pp_o
);

  always_comb begin
    pp_o = '0;
    for (int unsigned i = 0; i < DIGIT; i++) begin
      if (digit_i[i]) pp_o = pp_o + ({{DIGIT{1'b0}}, mag_a_i} << i);
    end
  end

endmodule

// File: rtl/mult_iter.sv
// mult_iter: multi-cycle integer multiplier, DIGIT multiplier bits per cycle.
//   clk       clock, rising edge
//   rst       synchronous reset, active-low
//   start     request, sampled only in IDLE
//   is_signed 1 = two's-complement operands, sampled with start
//   a, b      multiplicand / multiplier [WIDTH], sampled with start
//   abort     cancel in-flight operation (CALC or FIX)
//   busy      high while CALC is running
//   done      one-cycle pulse, result valid
//   result    product [2*WIDTH], held until the next completed operation
module mult_iter
  import mult_iter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned N      = num_steps(WIDTH, DIGIT);
  localparam int unsigned STEP_W = clog2(N);
  localparam int unsigned ACC_W  = 2 * WIDTH;

  if ((WIDTH % DIGIT) != 0) begin : g_digit_check
    $fatal(1, "mult_iter: WIDTH must be a multiple of DIGIT");
  end

  state_e             state_q;
  logic [WIDTH-1:0]   mag_a_q, mag_b_q;
  logic               neg_q;
  logic [ACC_W-1:0]   acc_q;
  logic [STEP_W-1:0]  step_q;
  logic               busy_q, done_q;
  logic [ACC_W-1:0]   result_q;

  logic [WIDTH-1:0]       mag_a_d, mag_b_d;
  logic [WIDTH+DIGIT-1:0] pp;
  logic [ACC_W-1:0]       pp_shifted;

  // Magnitudes fit in WIDTH bits unsigned, so -2^(WIDTH-1) maps to itself.
  always_comb begin
    mag_a_d = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
    mag_b_d = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  end

  mult_pp_digit #(
    .WIDTH(WIDTH),
    .DIGIT(DIGIT)
  ) u_pp (
    .mag_a_i(mag_a_q),
    .digit_i(mag_b_q[DIGIT-1:0]),
    .pp_o   (pp)
  );

  assign pp_shifted = ACC_W'(pp) << (32'(step_q) * 32'(DIGIT));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && !abort) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            mag_a_q <= mag_a_d;
            mag_b_q <= mag_b_d;
            neg_q   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc_q   <= '0;
            step_q  <= '0;
          end
        end
        CALC: begin
          if (abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q   <= acc_q + pp_shifted;
            mag_b_q <= mag_b_q >> DIGIT;
            step_q  <= step_q + STEP_W'(1);
            // busy covers only the CALC cycles; it is already low in FIX.
            if (step_q == STEP_W'(N - 1)) begin
              state_q <= FIX;
              busy_q  <= 1'b0;
            end
          end
        end
        FIX: begin
          state_q <= IDLE;
          if (!abort) begin
            result_q <= neg_q ? (~acc_q + ACC_W'(1)) : acc_q;
            done_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
